// File: rtl/chroma_upsample_fir.sv
// Multi-channel 2x chroma upsampler. Emits each input sample together with a
// 6-tap symmetric-FIR midpoint, computed on a single shared multiplier.
module chroma_upsample_fir #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 8,
    parameter int COEF0    = 21,
    parameter int COEF1    = 52,
    parameter int COEF2    = 159,
    parameter int ROUND    = 128,
    parameter int SHIFT    = 8
) (
    input  logic                         CLOCK_50_I,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sol,
    input  logic                         in_eol,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sol,
    output logic                         out_eol,
    output logic [CHANNELS*DATA_W-1:0]   out_even,
    output logic [CHANNELS*DATA_W-1:0]   out_odd,
    output logic                         err_protocol
);

    localparam int ACC_W = DATA_W + 12;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MAX_V = (1 << DATA_W) - 1;

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, MAC, OUT} state_t;

    state_t                  state;
    logic [DATA_W-1:0]       win [CHANNELS][6];
    logic [1:0]              shift_cnt;
    logic [1:0]              flush_left;
    logic [1:0]              tap_idx;
    logic [CH_W-1:0]         ch_idx;
    logic                    sol_pend;
    logic                    eol_seen;
    logic signed [ACC_W-1:0] acc;

    logic                    accept;
    logic [1:0]              cnt_inc;

    assign accept  = in_valid & in_ready;
    assign cnt_inc = (shift_cnt == 2'd3) ? 2'd3 : shift_cnt + 2'd1;

    // Shared MAC datapath: one symmetric tap pair of one channel per cycle.
    logic [2:0]              mirror_idx;
    logic [DATA_W-1:0]       tap_a;
    logic [DATA_W-1:0]       tap_b;
    logic signed [ACC_W-1:0] pair_s;
    logic signed [ACC_W-1:0] coef_s;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       odd_clip;

    always_comb begin
        mirror_idx = 3'd5 - {1'b0, tap_idx};
        tap_a      = win[ch_idx][tap_idx];
        tap_b      = win[ch_idx][mirror_idx];
        pair_s     = ACC_W'({1'b0, tap_a} + {1'b0, tap_b});
        case (tap_idx)
            2'd0:    coef_s = ACC_W'(COEF0);
            2'd1:    coef_s = ACC_W'(COEF1);
            default: coef_s = ACC_W'(COEF2);
        endcase
        prod     = pair_s * coef_s;
        term     = (tap_idx == 2'd1) ? -prod : prod;
        acc_next = (tap_idx == 2'd0) ? term : acc + term;
        rounded  = acc_next + ACC_W'(ROUND);
        shifted  = rounded >>> SHIFT;
        if (shifted < 0)
            odd_clip = '0;
        else if (shifted > ACC_W'(MAX_V))
            odd_clip = '1;
        else
            odd_clip = shifted[DATA_W-1:0];
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_sol      <= 1'b0;
            out_eol      <= 1'b0;
            out_even     <= '0;
            out_odd      <= '0;
            err_protocol <= 1'b0;
            shift_cnt    <= '0;
            flush_left   <= '0;
            tap_idx      <= '0;
            ch_idx       <= '0;
            sol_pend     <= 1'b0;
            eol_seen     <= 1'b0;
            acc          <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++)
                for (int unsigned k = 0; k < 6; k++)
                    win[c][k] <= '0;
        end else if (accept && in_sol) begin
            // A sol in RUN abandons the partial line and restarts from here.
            if (state == RUN)
                err_protocol <= 1'b1;
            for (int unsigned c = 0; c < CHANNELS; c++)
                for (int unsigned k = 0; k < 6; k++)
                    win[c][k] <= in_data[c*DATA_W +: DATA_W];
            shift_cnt <= '0;
            sol_pend  <= 1'b1;
            eol_seen  <= in_eol;
            if (in_eol) begin
                flush_left <= 2'd3;
                state      <= FLUSH;
                in_ready   <= 1'b0;
            end else begin
                flush_left <= '0;
                state      <= RUN;
                in_ready   <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid)
                        err_protocol <= 1'b1;
                end
                RUN: begin
                    if (in_valid) begin
                        for (int unsigned c = 0; c < CHANNELS; c++) begin
                            for (int unsigned k = 0; k < 5; k++)
                                win[c][k] <= win[c][k+1];
                            win[c][5] <= in_data[c*DATA_W +: DATA_W];
                        end
                        shift_cnt <= cnt_inc;
                        if (in_eol) begin
                            flush_left <= 2'd3;
                            eol_seen   <= 1'b1;
                        end
                        if (cnt_inc == 2'd3) begin
                            state    <= MAC;
                            in_ready <= 1'b0;
                            ch_idx   <= '0;
                            tap_idx  <= '0;
                        end else if (in_eol) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        for (int unsigned k = 0; k < 5; k++)
                            win[c][k] <= win[c][k+1];
                        win[c][5] <= win[c][5];
                    end
                    flush_left <= flush_left - 2'd1;
                    shift_cnt  <= cnt_inc;
                    if (cnt_inc == 2'd3) begin
                        state   <= MAC;
                        ch_idx  <= '0;
                        tap_idx <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap_idx == 2'd2) begin
                        out_odd[ch_idx*DATA_W +: DATA_W]  <= odd_clip;
                        out_even[ch_idx*DATA_W +: DATA_W] <= win[ch_idx][2];
                        tap_idx <= '0;
                        if (ch_idx == CH_W'(CHANNELS - 1)) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_sol   <= sol_pend;
                            out_eol   <= eol_seen && (flush_left == 2'd0);
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end else begin
                        tap_idx <= tap_idx + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_sol   <= 1'b0;
                        out_eol   <= 1'b0;
                        sol_pend  <= 1'b0;
                        if (flush_left != 2'd0) begin
                            state <= FLUSH;
                        end else if (eol_seen) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            eol_seen <= 1'b0;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
